pc_rx_word_buffer: RTL

PC_RX_WORD_BUFFER -- requirements
Module: pc_rx_word_buffer

---
 rtl/pc_rx_word_buffer_pkg.sv | 24 ++
 rtl/pc_rx_sync_fifo.sv | 76 +++++++
 rtl/pc_rx_word_buffer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pc_rx_word_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_rx_word_buffer_pkg
//  Description : Shared constants and types for the UART RX word buffer:
//                assembler state encoding, default parameter values and the
//                UART clocks-per-bit figure the timeout default is built on.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_rx_word_buffer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,   // no bytes of a word held
        ST_ASSEMBLE = 1'b1    // 1..BYTES_PER_WORD-1 bytes held
    } asm_state_t;

    localparam int unsigned c_clks_per_bit          = 435;
    localparam int unsigned c_default_bytes_per_word = 4;
    localparam int unsigned c_default_fifo_depth     = 16;
    // Ten bit-times of silence mid-word means the sender lost framing.
    localparam int unsigned c_default_timeout_clks   = 10 * c_clks_per_bit;
    localparam int unsigned c_default_msb_first      = 1;

endpackage : pc_rx_word_buffer_pkg
`default_nettype wire

// File: rtl/pc_rx_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pc_rx_sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. The head word is
//                always presented on o_rd_data; i_rd_en consumes it.
//  Ports       : i_clock, i_reset_n (async active-low), i_flush (sync clear),
//                i_wr_en/i_wr_data (push), i_rd_en (pop), o_rd_data (head),
//                o_empty, o_full, o_level (words stored).
//  Revision    : 1.0  initial release
// ============================================================================
module pc_rx_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [AW:0]      o_level
);

    localparam logic [AW:0] c_full_level = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_rd;
    logic             w_do_wr;

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only
    // accepted when a pop frees the slot in the same cycle.
    assign w_do_rd = i_rd_en && (r_level != '0);
    assign w_do_wr = i_wr_en && ((r_level != c_full_level) || w_do_rd);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == c_full_level);
    assign o_level   = r_level;

endmodule : pc_rx_sync_fifo
`default_nettype wire

// File: rtl/pc_rx_word_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_rx_word_buffer
//  Description : Assembles UART RX bytes into BYTES_PER_WORD-byte words and
//                queues them in a FWFT FIFO. A stalled partial word is
//                dropped after TIMEOUT_CLKS idle clocks (o_resync_pulse);
//                words that find the FIFO full are counted and dropped.
//  Ports       : i_clock, i_reset_n (async active-low), i_rx_byte,
//                i_rx_byte_valid, i_flush, i_read_next_word_cmd,
//                o_fifo_output_word, o_fifo_is_empty_sig, o_fifo_is_full_sig,
//                o_fifo_level, o_overflow_count, o_resync_pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_rx_word_buffer
    import pc_rx_word_buffer_pkg::*;
#(
    parameter int BYTES_PER_WORD = c_default_bytes_per_word,
    parameter int FIFO_DEPTH     = c_default_fifo_depth,
    parameter int TIMEOUT_CLKS   = c_default_timeout_clks,
    parameter int MSB_FIRST      = c_default_msb_first,
    localparam int W             = 8 * BYTES_PER_WORD,
    localparam int LW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic [7:0]    i_rx_byte,
    input  logic          i_rx_byte_valid,
    input  logic          i_flush,
    input  logic          i_read_next_word_cmd,
    output logic [W-1:0]  o_fifo_output_word,
    output logic          o_fifo_is_empty_sig,
    output logic          o_fifo_is_full_sig,
    output logic [LW-1:0] o_fifo_level,
    output logic [15:0]   o_overflow_count,
    output logic          o_resync_pulse
);

    localparam int CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] c_last_byte = CW'(BYTES_PER_WORD - 1);
    localparam logic [TW-1:0] c_to_last   = TW'(TIMEOUT_CLKS - 1);

    asm_state_t    r_state;
    asm_state_t    w_state_next;
    logic [CW-1:0] r_byte_cnt;
    logic [CW-1:0] w_byte_cnt_next;
    logic [TW-1:0] r_to_cnt;
    logic [TW-1:0] w_to_cnt_next;
    logic [7:0]    r_bytes [BYTES_PER_WORD];
    logic          w_commit;
    logic          w_timeout;
    logic [W-1:0]  w_commit_word;
    logic          w_overflow;
    logic [15:0]   r_overflow_count;
    logic          r_resync_pulse;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_to_cnt   <= w_to_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_byte_cnt_next = r_byte_cnt;
        w_to_cnt_next   = r_to_cnt;
        w_commit        = 1'b0;
        w_timeout       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_byte_cnt_next = '0;
                w_to_cnt_next   = '0;
                if (i_rx_byte_valid) begin
                    if (BYTES_PER_WORD == 1) begin
                        w_commit = 1'b1;
                    end else begin
                        w_state_next    = ST_ASSEMBLE;
                        w_byte_cnt_next = CW'(1);
                    end
                end
            end
            ST_ASSEMBLE: begin
                // A byte in the expiry cycle wins over the timeout.
                if (i_rx_byte_valid) begin
                    w_to_cnt_next = '0;
                    if (r_byte_cnt == c_last_byte) begin
                        w_commit        = 1'b1;
                        w_state_next    = ST_IDLE;
                        w_byte_cnt_next = '0;
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + CW'(1);
                    end
                end else if (r_to_cnt == c_to_last) begin
                    w_timeout       = 1'b1;
                    w_state_next    = ST_IDLE;
                    w_byte_cnt_next = '0;
                    w_to_cnt_next   = '0;
                end else begin
                    w_to_cnt_next = r_to_cnt + TW'(1);
                end
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_byte_cnt_next = '0;
                w_to_cnt_next   = '0;
            end
        endcase
        if (i_flush) begin
            w_state_next    = ST_IDLE;
            w_byte_cnt_next = '0;
            w_to_cnt_next   = '0;
            w_commit        = 1'b0;
            w_timeout       = 1'b0;
        end
    end

    // ------------------------------------------------------ byte assembly
    // Slot BYTES_PER_WORD-1 is never read back: the final byte is taken
    // straight from i_rx_byte so the word commits on the last strobe.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                r_bytes[i] <= '0;
            end
        end else if (i_rx_byte_valid && !i_flush) begin
            r_bytes[r_byte_cnt] <= i_rx_byte;
        end
    end

    always_comb begin
        w_commit_word = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (MSB_FIRST != 0) begin
                w_commit_word[W-1-8*i -: 8] = (i == BYTES_PER_WORD-1) ? i_rx_byte : r_bytes[i];
            end else begin
                w_commit_word[8*i +: 8]     = (i == BYTES_PER_WORD-1) ? i_rx_byte : r_bytes[i];
            end
        end
    end

    // ---------------------------------------------- overflow and resync
    assign w_overflow = w_commit && o_fifo_is_full_sig && !i_read_next_word_cmd;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overflow_count <= '0;
            r_resync_pulse   <= 1'b0;
        end else begin
            r_resync_pulse <= w_timeout;
            if (w_overflow && (r_overflow_count != 16'hFFFF)) begin
                r_overflow_count <= r_overflow_count + 16'd1;
            end
        end
    end

    assign o_overflow_count = r_overflow_count;
    assign o_resync_pulse   = r_resync_pulse;

    // ------------------------------------------------------------ storage
    pc_rx_sync_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_flush   (i_flush),
        .i_wr_en   (w_commit),
        .i_wr_data (w_commit_word),
        .i_rd_en   (i_read_next_word_cmd && !i_flush),
        .o_rd_data (o_fifo_output_word),
        .o_empty   (o_fifo_is_empty_sig),
        .o_full    (o_fifo_is_full_sig),
        .o_level   (o_fifo_level)
    );

endmodule : pc_rx_word_buffer
`default_nettype wire
